line_window_reader: RTL
=======================

// Module: line_window_reader
// PURPOSE
//   Streaming client of two dual-port line BRAMs (DATA_W x 2**ADDR_W, 1-cycle registered read, read-first).
//   Accepts raster pixels, writes them into line memory L1, cascades L1 old data into L2, and emits 3-pixel
//   vertical columns (rows y-2, y-1, y) to the median-filter window stage. Sits between pixel input and the 3x3 sorter.
// PARAMETERS
//   DATA_W   24    pixel width (RGB888)
//   ADDR_W   11    line memory address width; line length <= 2**ADDR_W
//   LINE_W   1280  pixels per line; legal range 2..2**ADDR_W
// PORTS
//   clk          in   1        system clock; every register in this block uses it
//   rst          in   1        synchronous reset, active high
//   in_valid     in   1        input pixel strobe; no backpressure
//   in_sof       in   1        start of frame; qualified by in_valid
//   in_data      in   DATA_W   input pixel
//   l1_we        out  1        L1 port A write enable
//   l1_addr      out  ADDR_W   L1 port A address (read and write)
//   l1_din       out  DATA_W   L1 port A write data
//   l1_dout      in   DATA_W   L1 port A read data, 1 cycle after l1_addr
//   l2_rd_addr   out  ADDR_W   L2 port A address; L2 port A write enable is tied 0 at top level
//   l2_rd_dout   in   DATA_W   L2 port A read data, 1 cycle after l2_rd_addr
//   l2_we        out  1        L2 port B write enable
//   l2_wr_addr   out  ADDR_W   L2 port B address
//   l2_din       out  DATA_W   L2 port B write data
//   col_valid    out  1        output column strobe
//   col_top      out  DATA_W   pixel (x, y-2); 0 if col_top_ok=0
//   col_mid      out  DATA_W   pixel (x, y-1); 0 if col_mid_ok=0
//   col_bot      out  DATA_W   pixel (x, y)
//   col_x        out  ADDR_W   column index of output
//   col_eol      out  1        col_x == LINE_W-1
//   col_mid_ok   out  1        row y-1 exists in this frame
//   col_top_ok   out  1        row y-2 exists in this frame
// BEHAVIOUR
//   Reset: x=0, row state FILL0; all outputs 0: col_*, l1_we, l2_we, addresses, din.
//   Counters: x advances on each in_valid, wrapping LINE_W-1 -> 0; on wrap the row FSM advances.
//   Row FSM: FILL0 -> FILL1 -> STEADY, changed only at line wrap; STEADY holds.
//   FSM state during the pixel: FILL0 => mid_ok=0, top_ok=0; FILL1 => mid_ok=1, top_ok=0; STEADY => both 1.
//   in_sof with in_valid: pixel is x=0 in FILL0, regardless of the current x/state. A partial previous line is
//   abandoned and the memories are not cleared. in_sof without in_valid is ignored.
//   Cycle t (in_valid): l1_we=1, l1_addr=x, l1_din=in_data; l2_rd_addr=x. This is combinational from in_valid/x.
//   l1_we=0 whenever in_valid=0. l1_addr and l2_rd_addr hold their last value when in_valid=0.
//   Cycle t+1: l1_dout = old L1[x] (read-first). l2_rd_dout = old L2[x].
//     Registered: l2_we=1, l2_wr_addr=x(t), l2_din=l1_dout. This cascades row y-1 into L2.
//     The same cycle captures into stage regs: bot=in_data(t), mid=l1_dout, top=l2_rd_dout, x, flags.
//   Cycle t+2: col_valid=1 for exactly one cycle per accepted pixel. Total latency 2 cycles.
//     col_* hold until the next col_valid. mid/top are forced to 0 when their ok flag is 0.
//   No hazards: L2 read (port A) of x+1 and L2 write (port B) of x never share an address in the same cycle,
//     because LINE_W>=2. L1 read/write at the same address in the same cycle returns old data by design.
//   Gaps in in_valid at any point: the pipeline advances per pixel only. Output order is preserved.
//   in_valid may be asserted every cycle: full throughput, 1 pixel/clk.
//   rst mid-frame: pipeline flushed. In-flight columns are never emitted. The next frame must start with in_sof.
// TESTING
//   1. Reset; in_valid=0 for 5 clk -> col_valid, l1_we, l2_we, and all col_* stay 0.
//   2. LINE_W=4, frame of 3 lines, values 0x000100+y*16+x, back-to-back -> 12 col_valid, each 2 clk after its input.
//      Line 2, x=1: top=0x000101, mid=0x000111, bot=0x000121, mid_ok=1, top_ok=1.
//   3. Same frame, line 0 -> mid=top=0 and ok flags 0. Line 1 -> mid=line-0 pixel, top=0, top_ok=0.
//      col_eol=1 at x=3 only.
//   4. Random in_valid gaps (~50% duty) on test 2 data -> identical column sequence; col values hold between strobes.
//   5. in_sof at line 1, x=2 of a previous frame -> that pixel reports col_x=0, mid_ok=0.
//      The next frame's line 1 returns the new frame's line-0 data.
//   6. rst asserted 1 clk after in_valid -> no col_valid follows.
//      Restart with in_sof -> behaviour identical to test 2.

Source files
------------

// File: rtl/line_window_reader.sv
// rtl/line_window_reader.sv - raster-to-column reader cascading line memory L1 into L2
// Emits (y-2, y-1, y) pixel columns two cycles after each accepted input pixel.
module line_window_reader #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 11,
   parameter int LINE_W = 1280
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_data,
   output logic              l1_we,
   output logic [ADDR_W-1:0] l1_addr,
   output logic [DATA_W-1:0] l1_din,
   input  logic [DATA_W-1:0] l1_dout,
   output logic [ADDR_W-1:0] l2_rd_addr,
   input  logic [DATA_W-1:0] l2_rd_dout,
   output logic              l2_we,
   output logic [ADDR_W-1:0] l2_wr_addr,
   output logic [DATA_W-1:0] l2_din,
   output logic              col_valid,
   output logic [DATA_W-1:0] col_top,
   output logic [DATA_W-1:0] col_mid,
   output logic [DATA_W-1:0] col_bot,
   output logic [ADDR_W-1:0] col_x,
   output logic              col_eol,
   output logic              col_mid_ok,
   output logic              col_top_ok
);

   typedef enum logic [1:0] {FILL0, FILL1, STEADY} row_e;

   localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(LINE_W - 1);

   row_e              row_q, row_d, cur_row;
   logic [ADDR_W-1:0] x_q, x_d, cur_x;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic              s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0] s1_x_q, s1_x_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic              s1_mid_ok_q, s1_mid_ok_d;
   logic              s1_top_ok_q, s1_top_ok_d;

   logic              col_valid_q, col_valid_d;
   logic [DATA_W-1:0] col_top_q, col_top_d;
   logic [DATA_W-1:0] col_mid_q, col_mid_d;
   logic [DATA_W-1:0] col_bot_q, col_bot_d;
   logic [ADDR_W-1:0] col_x_q, col_x_d;
   logic              col_eol_q, col_eol_d;
   logic              col_mid_ok_q, col_mid_ok_d;
   logic              col_top_ok_q, col_top_ok_d;

   always_comb begin
      // A start-of-frame pixel overrides whatever line position we were at.
      cur_x   = x_q;
      cur_row = row_q;
      if (in_valid && in_sof) begin
         cur_x   = '0;
         cur_row = FILL0;
      end

      x_d         = x_q;
      row_d       = row_q;
      addr_d      = addr_q;
      s1_valid_d  = in_valid;
      s1_x_d      = s1_x_q;
      s1_data_d   = s1_data_q;
      s1_mid_ok_d = s1_mid_ok_q;
      s1_top_ok_d = s1_top_ok_q;

      if (in_valid) begin
         addr_d      = cur_x;
         s1_x_d      = cur_x;
         s1_data_d   = in_data;
         s1_mid_ok_d = (cur_row != FILL0);
         s1_top_ok_d = (cur_row == STEADY);
         row_d       = cur_row;
         if (cur_x == LAST_X) begin
            x_d = '0;
            if (cur_row == FILL0) row_d = FILL1;
            else                  row_d = STEADY;
         end else begin
            x_d = cur_x + 1'b1;
         end
      end

      col_valid_d  = s1_valid_q;
      col_top_d    = col_top_q;
      col_mid_d    = col_mid_q;
      col_bot_d    = col_bot_q;
      col_x_d      = col_x_q;
      col_eol_d    = col_eol_q;
      col_mid_ok_d = col_mid_ok_q;
      col_top_ok_d = col_top_ok_q;

      if (s1_valid_q) begin
         col_bot_d    = s1_data_q;
         col_mid_d    = s1_mid_ok_q ? l1_dout : '0;
         col_top_d    = s1_top_ok_q ? l2_rd_dout : '0;
         col_x_d      = s1_x_q;
         col_eol_d    = (s1_x_q == LAST_X);
         col_mid_ok_d = s1_mid_ok_q;
         col_top_ok_d = s1_top_ok_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q          <= '0;
         row_q        <= FILL0;
         addr_q       <= '0;
         s1_valid_q   <= 1'b0;
         s1_x_q       <= '0;
         s1_data_q    <= '0;
         s1_mid_ok_q  <= 1'b0;
         s1_top_ok_q  <= 1'b0;
         col_valid_q  <= 1'b0;
         col_top_q    <= '0;
         col_mid_q    <= '0;
         col_bot_q    <= '0;
         col_x_q      <= '0;
         col_eol_q    <= 1'b0;
         col_mid_ok_q <= 1'b0;
         col_top_ok_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         s1_valid_q   <= s1_valid_d;
         s1_x_q       <= s1_x_d;
         s1_data_q    <= s1_data_d;
         s1_mid_ok_q  <= s1_mid_ok_d;
         s1_top_ok_q  <= s1_top_ok_d;
         col_valid_q  <= col_valid_d;
         col_top_q    <= col_top_d;
         col_mid_q    <= col_mid_d;
         col_bot_q    <= col_bot_d;
         col_x_q      <= col_x_d;
         col_eol_q    <= col_eol_d;
         col_mid_ok_q <= col_mid_ok_d;
         col_top_ok_q <= col_top_ok_d;
      end
   end

   // L1 old data read this cycle is row y-1; it is pushed into L2 at the same x.
   assign l1_we      = in_valid;
   assign l1_addr    = in_valid ? cur_x : addr_q;
   assign l1_din     = in_valid ? in_data : '0;
   assign l2_rd_addr = in_valid ? cur_x : addr_q;
   assign l2_we      = s1_valid_q;
   assign l2_wr_addr = s1_x_q;
   assign l2_din     = s1_valid_q ? l1_dout : '0;

   assign col_valid  = col_valid_q;
   assign col_top    = col_top_q;
   assign col_mid    = col_mid_q;
   assign col_bot    = col_bot_q;
   assign col_x      = col_x_q;
   assign col_eol    = col_eol_q;
   assign col_mid_ok = col_mid_ok_q;
   assign col_top_ok = col_top_ok_q;

endmodule
